// File: rtl/pipe_mem_access_pkg.sv
// Shared encodings for the MEM stage: result-select codes, access FSM states and
// the MEM/WB register payload with its bubble value.
package pipe_mem_access_pkg;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic        wreg;
    logic [1:0]  m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
    logic        mfhi;
    logic        mflo;
  } mw_t;

  // A bubble carries no write enables, so WB retires nothing for it.
  localparam mw_t MW_BUBBLE = '0;

endpackage

// File: rtl/pipe_mem_access_pipemwreg.sv
// MEM/WB pipeline register: captures a completed MEM result or inserts a bubble.
module pipemwreg
  import pipe_mem_access_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic load,
  input  logic bubble,
  input  mw_t  d,
  output mw_t  q
);

  mw_t mw_q;
  mw_t mw_d;

  always_comb begin
    // NOTE: default assignment first so every path drives mw_d and no latch is inferred.
    mw_d = mw_q;
    if (bubble) begin
      mw_d = MW_BUBBLE;
    end else if (load) begin
      mw_d = d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      mw_q <= MW_BUBBLE;
    end else begin
      mw_q <= mw_d;
    end
  end

  assign q = mw_q;

endmodule

// File: rtl/pipe_mem_access.sv
// MEM-stage data-memory access controller: req/ack handshake with a wait watchdog,
// upstream stall generation and the MEM/WB register feeding WB.
module pipe_mem_access
  import pipe_mem_access_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwreg,
  input  logic [1:0]  mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  input  logic        mmfhi,
  input  logic        mmflo,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        wwreg,
  output logic [1:0]  wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        wmfhi,
  output logic        wmflo
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
  logic          data_ok;
  logic          is_load;
  logic          access;
  mw_t           mw_in;
  mw_t           mw_out;

  // A store takes priority over a load select, so it never returns load data.
  assign is_load = (mm2reg == M2R_MEM) && !mwmem;
  assign access  = mwmem || (mm2reg == M2R_MEM);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    data_ok   = 1'b0;
    // Reset forces the handshake and stall quiet regardless of EX/MEM contents.
    if (!clrn) begin
      case (state_q)
        IDLE: begin
          if (access) begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
              data_ok = 1'b1;
            end else begin
              mem_stall = 1'b1;
              state_d   = WAIT;
              cnt_d     = CW'(1);
            end
          end
        end
        WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            data_ok = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(WAIT_MAX)) begin
            bus_err_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    mw_in.wreg  = mwreg;
    mw_in.m2reg = mm2reg;
    mw_in.mo    = (data_ok && is_load) ? dmem_rdata : 32'h0;
    mw_in.alu   = malu;
    mw_in.rn    = mrn;
    mw_in.mfhi  = mmfhi;
    mw_in.mflo  = mmflo;
  end

  pipemwreg u_mwreg (
    .clk    (clk),
    .clrn   (clrn),
    .load   (!mem_stall),
    .bubble (mem_stall),
    .d      (mw_in),
    .q      (mw_out)
  );

  assign dmem_we    = mwmem;
  assign dmem_addr  = malu;
  assign dmem_wdata = mb;
  assign bus_err    = bus_err_q;

  assign wwreg  = mw_out.wreg;
  assign wm2reg = mw_out.m2reg;
  assign wmo    = mw_out.mo;
  assign walu   = mw_out.alu;
  assign wrn    = mw_out.rn;
  assign wmfhi  = mw_out.mfhi;
  assign wmflo  = mw_out.mflo;

endmodule

// File: tb/tb_pipe_mem_access.sv
// Directed bench for pipe_mem_access: single-cycle vector table plus hand-written
// wait, watchdog and mid-access reset sequences.
module tb_pipe_mem_access;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mwreg;
  logic [1:0]  mm2reg;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [4:0]  mrn;
  logic        mmfhi;
  logic        mmflo;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall;
  logic        bus_err;
  logic        wwreg;
  logic [1:0]  wm2reg;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wrn;
  logic        wmfhi;
  logic        wmflo;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_mem_access #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .mwreg      (mwreg),
    .mm2reg     (mm2reg),
    .mwmem      (mwmem),
    .malu       (malu),
    .mb         (mb),
    .mrn        (mrn),
    .mmfhi      (mmfhi),
    .mmflo      (mmflo),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .mem_stall  (mem_stall),
    .bus_err    (bus_err),
    .wwreg      (wwreg),
    .wm2reg     (wm2reg),
    .wmo        (wmo),
    .walu       (walu),
    .wrn        (wrn),
    .wmfhi      (wmfhi),
    .wmflo      (wmflo)
  );

  typedef struct {
    string       name;
    logic        mwreg;
    logic [1:0]  mm2reg;
    logic        mwmem;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [4:0]  mrn;
    logic        mmfhi;
    logic        mmflo;
    logic [31:0] rdata;
    logic        ack;
    logic        e_req;
    logic        e_stall;
    logic        e_wwreg;
    logic [1:0]  e_wm2reg;
    logic [31:0] e_wmo;
    logic [31:0] e_walu;
    logic [4:0]  e_wrn;
    logic        e_wmfhi;
    logic        e_wmflo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mwreg = 1'b0; mm2reg = 2'b00; mwmem = 1'b0; malu = 32'h0; mb = 32'h0;
    mrn = 5'd0; mmfhi = 1'b0; mmflo = 1'b0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
  endtask

  vec_t vecs[6];
  int   stall_cycles;
  bit   done;

  initial begin
    // name, mwreg, mm2reg, mwmem, malu, mb, mrn, fhi, flo, rdata, ack,
    // req, stall, wwreg, wm2reg, wmo, walu, wrn, wmfhi, wmflo
    vecs[0] = '{"zw_load", 1, 2'b01, 0, 32'h100, 32'h0, 5'd5, 0, 0, 32'hCAFEF00D, 1,
                1, 0, 1, 2'b01, 32'hCAFEF00D, 32'h100, 5'd5, 0, 0};
    vecs[1] = '{"hilo_pass", 0, 2'b00, 0, 32'h7, 32'h0, 5'd0, 1, 1, 32'hDEADBEEF, 0,
                0, 0, 0, 2'b00, 32'h0, 32'h7, 5'd0, 1, 1};
    vecs[2] = '{"stray_ack", 1, 2'b00, 0, 32'h55, 32'h0, 5'd31, 0, 0, 32'hFFFFFFFF, 1,
                0, 0, 1, 2'b00, 32'h0, 32'h55, 5'd31, 0, 0};
    vecs[3] = '{"zw_store", 0, 2'b00, 1, 32'h40, 32'hA5A5A5A5, 5'd3, 0, 0, 32'h1111, 1,
                1, 0, 0, 2'b00, 32'h0, 32'h40, 5'd3, 0, 0};
    vecs[4] = '{"store_wins", 1, 2'b01, 1, 32'h44, 32'h1, 5'd7, 0, 1, 32'hABCD, 1,
                1, 0, 1, 2'b01, 32'h0, 32'h44, 5'd7, 0, 1};
    vecs[5] = '{"m2r_rsvd", 1, 2'b10, 0, 32'h88, 32'h0, 5'd12, 1, 0, 32'h99, 1,
                0, 0, 1, 2'b10, 32'h0, 32'h88, 5'd12, 1, 0};

    // Reset with a store pending: handshake and stall must stay quiet.
    drive_idle();
    clrn = 1'b1; mwmem = 1'b1; mwreg = 1'b1; dmem_ack = 1'b0;
    tick(); tick();
    check("rst_req", dmem_req, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_wwreg", wwreg, 0);
    check("rst_wmo", wmo, 0);
    check("rst_walu", walu, 0);
    check("rst_wfhi_wflo", {wmfhi, wmflo}, 0);
    check("rst_bus_err", bus_err, 0);
    drive_idle();
    clrn = 1'b0;
    tick();

    foreach (vecs[i]) begin
      mwreg = vecs[i].mwreg; mm2reg = vecs[i].mm2reg; mwmem = vecs[i].mwmem;
      malu = vecs[i].malu; mb = vecs[i].mb; mrn = vecs[i].mrn;
      mmfhi = vecs[i].mmfhi; mmflo = vecs[i].mmflo;
      dmem_rdata = vecs[i].rdata; dmem_ack = vecs[i].ack;
      #1;
      check({vecs[i].name, "_req"}, dmem_req, vecs[i].e_req);
      check({vecs[i].name, "_stall"}, mem_stall, vecs[i].e_stall);
      if (vecs[i].e_req) check({vecs[i].name, "_we"}, dmem_we, vecs[i].mwmem);
      tick();
      check({vecs[i].name, "_wwreg"}, wwreg, vecs[i].e_wwreg);
      check({vecs[i].name, "_wm2reg"}, wm2reg, vecs[i].e_wm2reg);
      check({vecs[i].name, "_wmo"}, wmo, vecs[i].e_wmo);
      check({vecs[i].name, "_walu"}, walu, vecs[i].e_walu);
      check({vecs[i].name, "_wrn"}, wrn, vecs[i].e_wrn);
      check({vecs[i].name, "_wmfhi"}, wmfhi, vecs[i].e_wmfhi);
      check({vecs[i].name, "_wmflo"}, wmflo, vecs[i].e_wmflo);
    end

    // Store acknowledged on the 4th request cycle: three stalled cycles, then one commit.
    drive_idle();
    mwmem = 1'b1; mwreg = 1'b1; malu = 32'h200; mb = 32'h12345678; mrn = 5'd4;
    mmfhi = 1'b1; mmflo = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("st3_req", dmem_req, 1);
      check("st3_stall", mem_stall, 1);
      check("st3_we", dmem_we, 1);
      check("st3_addr", dmem_addr, 32'h200);
      check("st3_wdata", dmem_wdata, 32'h12345678);
      tick();
      check("st3_bubble_wwreg", wwreg, 0);
      check("st3_bubble_hilo", {wmfhi, wmflo}, 0);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h00000BAD;
    #1;
    check("st3_ack_stall", mem_stall, 0);
    check("st3_ack_req", dmem_req, 1);
    tick();
    check("st3_commit_wwreg", wwreg, 1);
    check("st3_commit_walu", walu, 32'h200);
    check("st3_commit_wmo", wmo, 0);
    check("st3_commit_hilo", {wmfhi, wmflo}, 2'b11);
    drive_idle();
    #1;
    check("st3_after_req", dmem_req, 0);
    tick();
    check("st3_after_wwreg", wwreg, 0);

    // Load that is never acknowledged: watchdog ends it after WAIT_MAX stalled cycles.
    drive_idle();
    mm2reg = 2'b01; mwreg = 1'b1; malu = 32'h300; mrn = 5'd9; dmem_rdata = 32'h5A5A5A5A;
    stall_cycles = 0;
    done = 1'b0;
    for (int c = 0; c < WAIT_MAX + 5 && !done; c++) begin
      #1;
      if (mem_stall) stall_cycles++;
      else done = 1'b1;
      tick();
    end
    check("wd_completed", done, 1);
    check("wd_stall_cycles", stall_cycles, WAIT_MAX);
    check("wd_wmo", wmo, 0);
    check("wd_wwreg", wwreg, 1);
    check("wd_wrn", wrn, 9);
    check("wd_bus_err", bus_err, 1);
    drive_idle();
    #1;
    check("wd_idle_req", dmem_req, 0);
    tick();
    mm2reg = 2'b01; mwreg = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h600D600D; mrn = 5'd2;
    #1;
    check("wd_next_nostall", mem_stall, 0);
    tick();
    check("wd_next_wmo", wmo, 32'h600D600D);
    check("wd_sticky_bus_err", bus_err, 1);

    // Reset asserted mid-wait: request and stall drop at once, nothing commits.
    drive_idle();
    mm2reg = 2'b01; mwreg = 1'b1; malu = 32'h400; mrn = 5'd11; mmfhi = 1'b1;
    tick(); tick();
    #1;
    check("arst_pre_stall", mem_stall, 1);
    clrn = 1'b1;
    #1;
    check("arst_req", dmem_req, 0);
    check("arst_stall", mem_stall, 0);
    check("arst_wwreg", wwreg, 0);
    check("arst_bus_err", bus_err, 0);
    tick();
    drive_idle();
    clrn = 1'b0;
    #1;
    check("arst_post_req", dmem_req, 0);
    tick();
    check("arst_post_wwreg", wwreg, 0);
    check("arst_post_wrn", wrn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
